snake_body_scan: RTL

Reader end of the `snake_body` ring buffer, in the `pix_clk` domain. After each game tick it walks every stored segment through a synchronous read port. It flags self-collision against the newly pushed head. It also rebuilds a double-buffered 40×30 occupancy bitmap, which the VGA raster queries for `body_on`.

---
 rtl/snake_pkg.sv | 35 +++
 rtl/occ_bitmap_ram.sv | 63 ++++++
 rtl/snake_body_scan.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// snake_pkg: grid constants, packed segment coordinate type, cell-address
// helper and scan FSM state type shared by the snake body logic.
package snake_pkg;

  localparam int GRID_W     = 40;
  localparam int GRID_H     = 30;
  localparam int XW         = 6;
  localparam int YW         = 5;
  localparam int MAX_LEN    = 128;
  localparam int LEN_W      = 8;
  localparam int GRID_CELLS = GRID_W * GRID_H;  // 1200
  localparam int CELL_BITS  = 11;

  // Segment coordinate as stored by snake_head / snake_body: {x,y}.
  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } coord_t;

  typedef logic [CELL_BITS-1:0] cell_addr_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_SCAN,
    S_FIN
  } scan_state_t;

  // Row-major bitmap address: y*GRID_W + x.
  function automatic cell_addr_t cell_addr(input logic [XW-1:0] x,
                                           input logic [YW-1:0] y);
    return cell_addr_t'(y) * cell_addr_t'(GRID_W) + cell_addr_t'(x);
  endfunction

endpackage

// File: rtl/occ_bitmap_ram.sv
// occ_bitmap_ram: double-buffered GRID_W x GRID_H occupancy bitmap.
// Writes go to the back bank; the raster reads the display bank through a
// registered port. 'swap' flips the banks and marks the new display bank
// valid; a bank that has never been completed reads as all-zero.
// Ports:
//   clk, reset_n       clock, async active-low reset
//   we, waddr, wdata   back-bank write port (waddr must be < GRID_CELLS)
//   swap               exchange display/back banks, set new display valid
//   rd_x, rd_y         raster cell to query
//   rd_bit             registered occupancy of (rd_x, rd_y)
module occ_bitmap_ram
  import snake_pkg::*;
#(
  parameter int GRID_W = snake_pkg::GRID_W,
  parameter int GRID_H = snake_pkg::GRID_H,
  parameter int XW     = snake_pkg::XW,
  parameter int YW     = snake_pkg::YW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we,
  input  cell_addr_t    waddr,
  input  logic          wdata,
  input  logic          swap,
  input  logic [XW-1:0] rd_x,
  input  logic [YW-1:0] rd_y,
  output logic          rd_bit
);

  localparam int CELLS = GRID_W * GRID_H;
  localparam logic [XW-1:0] X_LIM = XW'(GRID_W);
  localparam logic [YW-1:0] Y_LIM = YW'(GRID_H);

  logic       mem [2][CELLS];
  logic       sel;
  logic [1:0] valid;
  logic       rd_in_grid;
  cell_addr_t raddr;

  assign rd_in_grid = (rd_x < X_LIM) && (rd_y < Y_LIM);
  assign raddr      = rd_in_grid ? cell_addr(rd_x, rd_y) : '0;

  // NOTE: the bitmap array has no reset; the per-bank valid bit masks its
  // contents until a full clear-and-rebuild has completed.
  always_ff @(posedge clk) begin
    if (we) mem[~sel][waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel    <= 1'b0;
      valid  <= 2'b00;
      rd_bit <= 1'b0;
    end else begin
      if (swap) begin
        sel         <= ~sel;
        valid[~sel] <= 1'b1;
      end
      rd_bit <= valid[sel] && rd_in_grid && mem[sel][raddr];
    end
  end

endmodule

// File: rtl/snake_body_scan.sv
// snake_body_scan: after each tick, clears the back bitmap bank, walks all
// stored segments via a 1-cycle-latency read port, marks their cells,
// flags self-collision with the captured head, then swaps banks.
// Optional feature macro: SNAKE_SELF_HIT_EN (head compare and 'hit';
// when undefined 'hit' is tied 0, everything else unchanged).
// Ports:
//   clk, reset_n          pixel clock, async active-low reset
//   start                 one-cycle scan request (ignored while busy)
//   head_x, head_y        new head cell, length: segment count
//   rd_addr / rd_data     segment read port, data 1 cycle after address
//   cell_x, cell_y        raster query, body_on: registered occupancy
//   busy, done, hit       status; done/hit are one-cycle pulses
module snake_body_scan
  import snake_pkg::*;
#(
  parameter int GRID_W  = snake_pkg::GRID_W,
  parameter int GRID_H  = snake_pkg::GRID_H,
  parameter int XW      = snake_pkg::XW,
  parameter int YW      = snake_pkg::YW,
  parameter int MAX_LEN = snake_pkg::MAX_LEN,
  parameter int LEN_W   = snake_pkg::LEN_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [XW-1:0]    head_x,
  input  logic [YW-1:0]    head_y,
  input  logic [LEN_W-1:0] length,
  output logic [6:0]       rd_addr,
  input  logic [XW+YW-1:0] rd_data,
  input  logic [XW-1:0]    cell_x,
  input  logic [YW-1:0]    cell_y,
  output logic             body_on,
  output logic             busy,
  output logic             done,
  output logic             hit
);

  localparam logic [XW-1:0]    X_LIM   = XW'(GRID_W);
  localparam logic [YW-1:0]    Y_LIM   = YW'(GRID_H);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  scan_state_t      state, state_nx;
  cell_addr_t       cnt;
  logic [LEN_W-1:0] len_q;
  coord_t           head_q;
  coord_t           rd_c;
  logic             issue_q;    // rd_data this cycle answers an issued address
  logic             idx0_q;     // ... and that address was index 0 (the head)
  logic             done_q;
  logic             we, wdata, swap;
  cell_addr_t       waddr;

  assign rd_c = rd_data;
  assign busy = (state != S_IDLE);
  assign done = done_q;

  // NOTE: every combinational output gets a default first so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_nx = state;
    we       = 1'b0;
    waddr    = '0;
    wdata    = 1'b0;
    swap     = 1'b0;
    rd_addr  = '0;
    unique case (state)
      S_IDLE:  if (start) state_nx = S_CLEAR;
      S_CLEAR: begin
        we    = 1'b1;
        waddr = cnt;
        if (cnt == cell_addr_t'(GRID_CELLS - 1)) state_nx = S_SCAN;
      end
      S_SCAN: begin
        rd_addr = cnt[6:0];
        if (issue_q && (rd_c.x < X_LIM) && (rd_c.y < Y_LIM)) begin
          we    = 1'b1;
          waddr = cell_addr(rd_c.x, rd_c.y);
          wdata = 1'b1;
        end
        // Counter reaching len means the last address went out last cycle
        // and its data is being consumed now.
        if (cnt == cell_addr_t'(len_q)) state_nx = S_FIN;
      end
      S_FIN: begin
        swap     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      len_q   <= '0;
      head_q  <= '0;
      issue_q <= 1'b0;
      idx0_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      issue_q <= (state == S_SCAN) && (cnt < cell_addr_t'(len_q));
      idx0_q  <= (cnt == '0);
      done_q  <= (state == S_FIN);
      if (state != state_nx)                         cnt <= '0;
      else if (state == S_CLEAR || state == S_SCAN)  cnt <= cnt + 1'b1;
      if (state == S_IDLE && start) begin
        head_q <= {head_x, head_y};
        len_q  <= (length > LEN_MAX) ? LEN_MAX : length;
      end
    end
  end

`ifdef SNAKE_SELF_HIT_EN
  logic hit_flag, hit_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_flag <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      if (state == S_IDLE && start)
        hit_flag <= 1'b0;
      else if (state == S_SCAN && issue_q && !idx0_q && rd_c == head_q)
        hit_flag <= 1'b1;
      hit_q <= (state == S_FIN) && hit_flag;
    end
  end

  assign hit = hit_q;
`else
  assign hit = 1'b0;
`endif

  occ_bitmap_ram #(
    .GRID_W(GRID_W),
    .GRID_H(GRID_H),
    .XW    (XW),
    .YW    (YW)
  ) u_bitmap (
    .clk    (clk),
    .reset_n(reset_n),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .swap   (swap),
    .rd_x   (cell_x),
    .rd_y   (cell_y),
    .rd_bit (body_on)
  );

endmodule
